// File: rtl/mmt_pkg.sv
// mmt_pkg: register offsets, STATUS/CTRL bit positions and FSM states for mmio_transpose_buf
package mmt_pkg;
   localparam logic [1:0] OFS_CTRL   = 2'd0;
   localparam logic [1:0] OFS_STATUS = 2'd1;
   localparam logic [1:0] OFS_DATA   = 2'd2;
   localparam logic [1:0] OFS_DIM    = 2'd3;
   localparam int ST_DRAIN_BIT   = 0;
   localparam int ST_EMPTY_BIT   = 1;
   localparam int ST_OVF_BIT     = 2;
   localparam int ST_UNF_BIT     = 3;
   localparam int ST_CNT_LSB     = 8;
   localparam int CTRL_CLR_BIT   = 0;
   localparam int CTRL_IRQEN_BIT = 1;
   typedef enum logic {ST_FILL, ST_DRAIN} state_t;
endpackage

// File: rtl/mmt_store.sv
// mmt_store: DIM*DIM x 16 storage, one synchronous write port and one combinational read port
module mmt_store #(
   parameter int LOG2_DIM = 2
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [2*LOG2_DIM-1:0] i_waddr,
   input  logic [15:0]           i_wdata,
   input  logic [2*LOG2_DIM-1:0] i_raddr,
   output logic [15:0]           o_rdata
);
   logic [15:0] r_mem [1 << (2*LOG2_DIM)];
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mmio_transpose_buf.sv
// mmio_transpose_buf: row-major fill / column-major drain matrix buffer on the per_* bus; MMT_IRQ_EN adds irq
module mmio_transpose_buf
   import mmt_pkg::*;
#(
   parameter logic [13:0] BASE_ADDR = 14'h090,
   parameter int          LOG2_DIM  = 2
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout
`ifdef MMT_IRQ_EN
   ,
   output logic        irq
`endif
);
   localparam int AW = 2*LOG2_DIM;
   localparam int CW = AW + 1;
   localparam int NE = 1 << AW;
   localparam logic [CW-1:0] LAST = CW'(NE - 1);
   localparam logic [CW-1:0] FULL = CW'(NE);
   logic [13:0]   w_ofs;
   logic [1:0]    w_reg;
   logic          w_hit, w_wr, w_rd, w_push, w_pop, w_clr, w_st_wr, w_ctrl_wr, w_drain;
   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_wcnt, r_rcnt, w_cnt;
   logic          r_ovf, r_unf;
   logic [AW-1:0] w_raddr;
   logic [15:0]   w_rdata, w_status, w_ctrl;
   assign w_ofs     = per_addr - BASE_ADDR;
   assign w_hit     = w_ofs < 14'd4;
   assign w_reg     = w_ofs[1:0];
   assign w_wr      = per_en && per_we == 2'b11 && w_hit;
   assign w_rd      = per_en && per_we == 2'b00 && w_hit;
   assign w_push    = w_wr && w_reg == OFS_DATA;
   assign w_pop     = w_rd && w_reg == OFS_DATA;
   assign w_ctrl_wr = w_wr && w_reg == OFS_CTRL;
   assign w_clr     = w_ctrl_wr && per_din[CTRL_CLR_BIT];
   assign w_st_wr   = w_wr && w_reg == OFS_STATUS;
   assign w_drain   = r_state == ST_DRAIN;
   always_ff @(posedge mclk) begin
      if (puc_rst) r_state <= ST_FILL;
      else r_state <= w_state_nxt;
   end
   always_comb begin
      w_state_nxt = r_state;
      if (w_clr) w_state_nxt = ST_FILL;
      else if (w_push && !w_drain && r_wcnt == LAST) w_state_nxt = ST_DRAIN;
      else if (w_pop && w_drain && r_rcnt == LAST) w_state_nxt = ST_FILL;
   end
   // Wrong-direction accesses only raise the sticky flags; counters stay put.
   always_ff @(posedge mclk) begin
      if (puc_rst || w_clr) begin
         r_wcnt <= '0;
         r_rcnt <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else begin
         if (w_push && !w_drain) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST) r_rcnt <= '0;
         end
         if (w_push && w_drain) r_ovf <= 1'b1;
         if (w_pop && w_drain) begin
            r_rcnt <= r_rcnt + 1'b1;
            if (r_rcnt == LAST) r_wcnt <= '0;
         end
         if (w_pop && !w_drain) r_unf <= 1'b1;
         if (w_st_wr && per_din[ST_OVF_BIT]) r_ovf <= 1'b0;
         if (w_st_wr && per_din[ST_UNF_BIT]) r_unf <= 1'b0;
      end
   end
   // Swapping the row/column fields of the pop index turns row-major storage into column-major reads.
   assign w_raddr = {r_rcnt[LOG2_DIM-1:0], r_rcnt[AW-1:LOG2_DIM]};
   mmt_store #(.LOG2_DIM(LOG2_DIM)) u_store (
      .i_clk   (mclk),
      .i_we    (w_push && !w_drain),
      .i_waddr (r_wcnt[AW-1:0]),
      .i_wdata (per_din),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );
`ifdef MMT_IRQ_EN
   logic r_irq_en, r_irq;
   always_ff @(posedge mclk) begin
      if (puc_rst) r_irq_en <= 1'b0;
      else if (w_ctrl_wr) r_irq_en <= per_din[CTRL_IRQEN_BIT];
   end
   always_ff @(posedge mclk) begin
      if (puc_rst) r_irq <= 1'b0;
      else r_irq <= r_irq_en && w_drain;
   end
   assign irq    = r_irq && w_drain;
   assign w_ctrl = 16'(r_irq_en) << CTRL_IRQEN_BIT;
`else
   assign w_ctrl = 16'h0;
`endif
   assign w_cnt    = w_drain ? FULL - r_rcnt : r_wcnt;
   assign w_status = (16'(w_cnt) << ST_CNT_LSB) | (16'(r_unf) << ST_UNF_BIT) | (16'(r_ovf) << ST_OVF_BIT)
                   | (16'(w_cnt == '0) << ST_EMPTY_BIT) | (16'(w_drain) << ST_DRAIN_BIT);
   assign per_dout = !w_rd                ? 16'h0 :
                     w_reg == OFS_CTRL    ? w_ctrl :
                     w_reg == OFS_STATUS  ? w_status :
                     w_reg == OFS_DATA    ? (w_drain ? w_rdata : 16'h0) :
                                            16'(1 << LOG2_DIM);
endmodule

// File: tb/tb_mmio_transpose_buf.sv
// tb_mmio_transpose_buf: directed checks of fill/drain, flags, access rules and irq (MMT_IRQ_EN builds)
module tb_mmio_transpose_buf;
   localparam logic [13:0] BASE = 14'h090;
   localparam logic [13:0] A_CTRL = BASE, A_STAT = BASE + 14'd1, A_DATA = BASE + 14'd2, A_DIM = BASE + 14'd3;
   logic        mclk = 1'b0;
   logic        puc_rst = 1'b1;
   logic [13:0] per_addr = '0;
   logic [15:0] per_din = '0;
   logic        per_en = 1'b0;
   logic [1:0]  per_we = 2'b00;
   logic [15:0] per_dout;
`ifdef MMT_IRQ_EN
   logic        irq;
`endif
   int n_pass = 0;
   int n_tot  = 0;
   logic [15:0] d;
   logic [15:0] col_order [16] = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd1, 16'd5, 16'd9, 16'd13,
                                   16'd2, 16'd6, 16'd10, 16'd14, 16'd3, 16'd7, 16'd11, 16'd15};
   mmio_transpose_buf #(.BASE_ADDR(BASE), .LOG2_DIM(2)) dut (
      .mclk     (mclk),
      .puc_rst  (puc_rst),
      .per_addr (per_addr),
      .per_din  (per_din),
      .per_en   (per_en),
      .per_we   (per_we),
      .per_dout (per_dout)
`ifdef MMT_IRQ_EN
      ,
      .irq      (irq)
`endif
   );
   always #5 mclk = ~mclk;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tot++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic wr(input logic [13:0] a, input logic [15:0] v, input logic [1:0] we = 2'b11);
      per_addr = a;
      per_din  = v;
      per_we   = we;
      per_en   = 1'b1;
      @(posedge mclk);
      #1;
      per_en = 1'b0;
      per_we = 2'b00;
   endtask
   task automatic rd(input logic [13:0] a, output logic [15:0] v);
      per_addr = a;
      per_we   = 2'b00;
      per_en   = 1'b1;
      #1;
      v = per_dout;
      @(posedge mclk);
      #1;
      per_en = 1'b0;
   endtask
   initial begin
      repeat (3) @(posedge mclk);
      #1 puc_rst = 1'b0;
      #1 chk("idle_dout", per_dout, 16'h0);
      rd(A_STAT, d); chk("rst_status", d, 16'h0002);
      rd(A_DIM, d);  chk("dimreg", d, 16'h0004);
      rd(A_CTRL, d); chk("rst_ctrl", d, 16'h0000);
      rd(BASE + 14'd4, d); chk("unmapped", d, 16'h0000);
      for (int i = 0; i < 16; i++) wr(A_DATA, 16'hA000 + 16'(i));
      rd(A_STAT, d); chk("full_status", d, 16'h1001);
      for (int i = 0; i < 16; i++) begin
         rd(A_DATA, d); chk($sformatf("pop1_%0d", i), d, 16'hA000 + col_order[i]);
      end
      rd(A_STAT, d); chk("drained_status", d, 16'h0002);
      for (int i = 0; i < 16; i++) wr(A_DATA, 16'hB000 + 16'(i));
      rd(A_DATA, d); chk("pop2_0", d, 16'hB000);
      rd(A_DATA, d); chk("pop2_1", d, 16'hB004);
      wr(A_DATA, 16'hBEEF);
      rd(A_STAT, d); chk("ovf_status", d, 16'h0E05);
      for (int i = 2; i < 16; i++) begin
         rd(A_DATA, d); chk($sformatf("pop2_%0d", i), d, 16'hB000 + col_order[i]);
      end
      rd(A_STAT, d); chk("ovf_sticky", d, 16'h0006);
      wr(A_STAT, 16'h0004);
      rd(A_STAT, d); chk("ovf_clear", d, 16'h0002);
      for (int i = 0; i < 3; i++) wr(A_DATA, 16'hC000 + 16'(i));
      rd(A_DATA, d); chk("unf_data", d, 16'h0000);
      rd(A_STAT, d); chk("unf_status", d, 16'h0308);
      wr(A_STAT, 16'h0008);
      rd(A_STAT, d); chk("unf_clear", d, 16'h0300);
      wr(A_DATA, 16'h1111, 2'b01);
      wr(A_DATA, 16'h2222, 2'b10);
      wr(A_CTRL, 16'h0001, 2'b01);
      rd(A_STAT, d); chk("byte_wr_ignored", d, 16'h0300);
      for (int i = 3; i < 16; i++) wr(A_DATA, 16'hC000 + 16'(i));
      for (int i = 0; i < 5; i++) begin
         rd(A_DATA, d); chk($sformatf("pop3_%0d", i), d, 16'hC000 + col_order[i]);
      end
      wr(A_CTRL, 16'h0003);
      rd(A_STAT, d); chk("clr_status", d, 16'h0002);
      rd(A_CTRL, d);
`ifdef MMT_IRQ_EN
      chk("ctrl_irqen", d, 16'h0002);
`else
      chk("ctrl_irqen", d, 16'h0000);
`endif
      for (int i = 0; i < 16; i++) wr(A_DATA, 16'hD000 + 16'(i));
`ifdef MMT_IRQ_EN
      chk("irq_not_yet", 16'(irq), 16'h0);
      @(posedge mclk); #1;
      chk("irq_rise", 16'(irq), 16'h1);
`endif
      rd(A_STAT, d); chk("refill_status", d, 16'h1001);
      for (int i = 0; i < 16; i++) begin
         rd(A_DATA, d); chk($sformatf("pop4_%0d", i), d, 16'hD000 + col_order[i]);
`ifdef MMT_IRQ_EN
         if (i == 14) chk("irq_held", 16'(irq), 16'h1);
`endif
      end
`ifdef MMT_IRQ_EN
      chk("irq_fall", 16'(irq), 16'h0);
`endif
      for (int i = 0; i < 5; i++) wr(A_DATA, 16'hE000 + 16'(i));
      rd(A_STAT, d); chk("midfill_status", d, 16'h0500);
      puc_rst = 1'b1;
      @(posedge mclk); #1;
      puc_rst = 1'b0;
      rd(A_STAT, d); chk("rst_abort_status", d, 16'h0002);
      rd(A_CTRL, d); chk("rst_ctrl_clear", d, 16'h0000);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/mmio_transpose_buf.md
# mmio_transpose_buf

Memory-mapped matrix-transpose buffer on the openMSP430 peripheral bus. Software pushes a DIM×DIM matrix of 16-bit words row-major through one data register and pops it back column-major through the same register. The block handles fill/drain sequencing, element counting, error flags and an optional interrupt. It is the parametrised successor to the fixed three-register peripheral and sits beside the other peripherals on the per_* bus, with its output OR-ed into the CPU read mux.

## Interface
- BASE_ADDR, 14'h090: word address of register offset 0 (per_addr units).
- LOG2_DIM, 2: matrix dimension DIM = 2**LOG2_DIM. Legal values are 1..3, giving DIM 2, 4 or 8 and up to 64 entries.

- mclk  in  1  system clock; the only clock.
- puc_rst  in  1  reset, **synchronous, active-high**.
- per_addr  in  14  word address.
- per_din  in  16  write data.
- per_en  in  1  active bus cycle.
- per_we  in  2  byte write enables; 2'b00 means read.
- per_dout  out  16  read data. Must be 16'h0 whenever this block is not being read.
- irq  out  1  level interrupt. Present only with MMT_IRQ_EN.

## Operation
Register map, by word offset from BASE_ADDR:
- +0 CTRL (R/W):
  - bit0 CLR: write-1 pulse, reads 0.
  - bit1 IRQ_EN.
  - All other bits read 0.
- +1 STATUS (R; write-1-to-clear on bits 2 and 3):
  - bit0 DRAIN.
  - bit1 EMPTY: count == 0.
  - bit2 OVF: sticky.
  - bit3 UNF: sticky.
  - [15:8] count.
- +2 DATA (R/W): push on write, pop on read.
- +3 DIMREG (R): returns DIM.

Access rules:
- A write takes effect only when per_en=1 and per_we=2'b11. Byte writes (01/10) are ignored completely.
- A read happens when per_en=1 and per_we=2'b00. Unmapped offsets return 0.

State machine (FILL and DRAIN):
- **FILL** (reset state):
  - A DATA write stores to mem[wcnt] and increments wcnt.
  - The write that makes wcnt = DIM² moves the block to DRAIN, with rcnt=0.
  - A DATA read returns 0, sets UNF and changes no counter.
- **DRAIN**:
  - A DATA read returns mem[{rcnt[LOG2_DIM-1:0], rcnt[2·LOG2_DIM-1:LOG2_DIM]}], i.e. the bit-fields of rcnt are swapped, then rcnt increments.
  - The read that makes rcnt = DIM² returns the block to FILL with wcnt=0.
  - A DATA write is dropped and sets OVF.
- count = wcnt in FILL, DIM²−rcnt in DRAIN.
- CLR, or puc_rst:
  - State becomes FILL; wcnt, rcnt, OVF and UNF become 0.
  - puc_rst also clears IRQ_EN.
  - Memory contents are not cleared.
- Values after reset:
  - per_dout = 0.
  - irq = 0.
  - STATUS reads 16'h0002.

## Timing
- Reads are combinational: per_dout is valid in the same cycle per_en is high.
- The pop side effect (rcnt++) and all register updates happen on the rising mclk edge ending that cycle.
- The state changes on the edge of the final push or pop. An access in the very next cycle already sees the new state; for example, element 0 can be read one cycle after the last write.
- A STATUS write-1-to-clear and a flag-setting event cannot coincide, because the bus carries one access per cycle.
- A CTRL write with CLR=1 and IRQ_EN=1 clears the pointers and sets IRQ_EN in the same edge.
- puc_rst asserted mid-fill or mid-drain aborts on the next edge. No partial state survives except memory contents.

## Configuration
- MMT_IRQ_EN defined:
  - The irq port exists.
  - irq = IRQ_EN & DRAIN, registered (asserts one cycle after DRAIN entry) and deasserts with DRAIN.
- MMT_IRQ_EN undefined:
  - No irq port.
  - CTRL bit1 is not stored and reads 0.

## Structure
- Package mmt_pkg holds:
  - register offsets: OFS_CTRL=0, OFS_STATUS=1, OFS_DATA=2, OFS_DIM=3;
  - STATUS bit indices;
  - the state enum {ST_FILL, ST_DRAIN}.
- Sub-module mmt_store: DIM²×16 storage with one synchronous write port and one combinational read port, parametrised by LOG2_DIM.
- Top level holds the address decode, the FSM, the counters, the flags and the read mux.

## Test plan
1. Reset: pulse puc_rst → STATUS=16'h0002, DIMREG=4, per_dout=0 when idle.
2. DIM=4: write 0..15 to DATA → STATUS=16'h1001. Then 16 reads → 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, and STATUS returns to 16'h0002.
3. In DRAIN after 2 pops, write 16'hBEEF to DATA → STATUS=16'h0E05. The remaining pops are unchanged (8,12,…).
4. FILL with count 3, read DATA → returns 0, STATUS=16'h0308. Write 16'h0008 to STATUS → 16'h0300.
5. per_we=2'b01 write to DATA → count unchanged, no OVF.
6. Mid-drain CTRL write of 16'h0003 → STATUS=16'h0002. Refill 16 words → irq rises one cycle after the 16th write (MMT_IRQ_EN build) and falls after the 16th pop.
